// File: rtl/mem_arb_pkg.sv
// Shared definitions for the memory-port arbiter: state encoding, widths
// and the index-width helper used for OWNER/LAST.
package mem_arb_pkg;

    localparam int MEM_ARB_MAX_PORTS = 4;
    localparam int MEM_ARB_AW        = 32;
    localparam int MEM_ARB_DW        = 32;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_ACCEPT = 3'd1;
    localparam logic [2:0] ST_ISSUE  = 3'd2;
    localparam logic [2:0] ST_WAIT   = 3'd3;
    localparam logic [2:0] ST_RESP   = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE   = ST_IDLE,
        S_ACCEPT = ST_ACCEPT,
        S_ISSUE  = ST_ISSUE,
        S_WAIT   = ST_WAIT,
        S_RESP   = ST_RESP
    } state_t;

    // Port index width; never below one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mem_arb_picker.sv
// Combinational winner selection for mem_arbiter.
// Default: round-robin starting after 'last', wrapping modulo NUM_PORTS.
// With MEM_ARB_FIXED_PRIO_EN defined: lowest valid index wins, 'last' ignored.
module mem_arb_picker
    import mem_arb_pkg::*;
#(
    parameter int NUM_PORTS = 2,
    parameter int IW        = 1
) (
    input  logic [NUM_PORTS-1:0] valid,
    input  logic [IW-1:0]        last,
    output logic [IW-1:0]        winner,
    output logic                 any_valid
);

`ifdef MEM_ARB_FIXED_PRIO_EN
    logic unused_last;
    assign unused_last = ^last;

    // Scan from the top down so the lowest valid index is the final winner.
    always_comb begin
        winner    = '0;
        any_valid = |valid;
        for (int i = NUM_PORTS - 1; i >= 0; i--) begin
            if (valid[i]) winner = i[IW-1:0];
        end
    end
`else
    // Visit candidates farthest-from-last first so the nearest port after
    // 'last' overwrites the others; 'last' itself has the lowest priority.
    always_comb begin
        int idx;
        idx       = 0;
        winner    = '0;
        any_valid = |valid;
        for (int k = NUM_PORTS; k >= 1; k--) begin
            idx = (int'(last) + k) % NUM_PORTS;
            if (valid[idx]) winner = idx[IW-1:0];
        end
    end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Shares one blocking cache port between NUM_PORTS requesters, one
// transaction at a time. Arbitration policy lives in mem_arb_picker;
// define MEM_ARB_FIXED_PRIO_EN there for fixed priority instead of
// round-robin.
// Handshake rule on every channel: a transfer happens on a rising edge where
// valid and ready are both high; the valid side holds its payload stable
// until then. All outputs come straight from registers.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int NUM_PORTS = 2
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [NUM_PORTS-1:0]            m_addr_valid,
    input  logic [MEM_ARB_AW*NUM_PORTS-1:0] m_addr,
    input  logic [NUM_PORTS-1:0]            m_data_valid,
    input  logic [MEM_ARB_DW*NUM_PORTS-1:0] m_data,
    output logic [NUM_PORTS-1:0]            m_ready,
    output logic [NUM_PORTS-1:0]            m_resp_valid,
    output logic [MEM_ARB_DW-1:0]           m_resp_data,
    input  logic [NUM_PORTS-1:0]            m_resp_ready,
    output logic                            c_addr_valid,
    output logic [MEM_ARB_AW-1:0]           c_addr,
    output logic                            c_data_valid,
    output logic [MEM_ARB_DW-1:0]           c_data,
    input  logic                            c_ready,
    input  logic                            c_send_valid,
    input  logic [MEM_ARB_DW-1:0]           c_send_data,
    output logic                            c_send_ready,
    output logic [NUM_PORTS-1:0]            grant,
    output logic                            busy,
    output state_t                          state_dbg
);

    localparam int IW = idx_width(NUM_PORTS);

    state_t                state;
    logic [IW-1:0]         owner;
    logic [IW-1:0]         last;
    logic [IW-1:0]         winner;
    logic                  any_valid;
    logic [NUM_PORTS-1:0]  win_oh;
    logic [NUM_PORTS-1:0]  own_oh;
    logic [MEM_ARB_AW-1:0] addr_r;
    logic [MEM_ARB_DW-1:0] data_r;
    logic [MEM_ARB_DW-1:0] resp_r;
    logic                  wr_r;

    mem_arb_picker #(
        .NUM_PORTS (NUM_PORTS),
        .IW        (IW)
    ) u_picker (
        .valid     (m_addr_valid),
        .last      (last),
        .winner    (winner),
        .any_valid (any_valid)
    );

    assign win_oh = {{(NUM_PORTS-1){1'b0}}, 1'b1} << winner;
    assign own_oh = {{(NUM_PORTS-1){1'b0}}, 1'b1} << owner;

    assign c_addr      = addr_r;
    assign c_data      = data_r;
    assign m_resp_data = resp_r;
    assign state_dbg   = state;

    // Transaction FSM; every externally visible strobe is set or cleared on
    // the transition into or out of the state that owns it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            owner        <= '0;
            last         <= IW'(NUM_PORTS - 1);
            addr_r       <= '0;
            data_r       <= '0;
            resp_r       <= '0;
            wr_r         <= 1'b0;
            m_ready      <= '0;
            m_resp_valid <= '0;
            c_addr_valid <= 1'b0;
            c_data_valid <= 1'b0;
            c_send_ready <= 1'b0;
            grant        <= '0;
            busy         <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (any_valid) begin
                        owner   <= winner;
                        m_ready <= win_oh;
                        grant   <= win_oh;
                        busy    <= 1'b1;
                        state   <= S_ACCEPT;
                    end
                end
                S_ACCEPT: begin
                    m_ready <= '0;
                    if (m_addr_valid[owner]) begin
                        addr_r       <= m_addr[int'(owner)*MEM_ARB_AW +: MEM_ARB_AW];
                        data_r       <= m_data[int'(owner)*MEM_ARB_DW +: MEM_ARB_DW];
                        wr_r         <= m_data_valid[owner];
                        c_addr_valid <= 1'b1;
                        c_data_valid <= m_data_valid[owner];
                        state        <= S_ISSUE;
                    end else begin
                        // Requester withdrew: drop ownership, keep the pointer.
                        grant <= '0;
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end
                end
                S_ISSUE: begin
                    if (c_ready) begin
                        c_addr_valid <= 1'b0;
                        c_data_valid <= 1'b0;
                        c_send_ready <= 1'b1;
                        state        <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (c_send_valid) begin
                        resp_r       <= c_send_data;
                        c_send_ready <= 1'b0;
                        m_resp_valid <= own_oh;
                        state        <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (m_resp_ready[owner]) begin
                        m_resp_valid <= '0;
                        last         <= owner;
                        grant        <= '0;
                        busy         <= 1'b0;
                        state        <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Write flag is only consumed through c_data_valid; keep the register
    // for observability of the captured request.
    logic unused_wr;
    assign unused_wr = wr_r;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: plays both the requesters and the cache, predicts
// the owner of each transaction from the arbitration rule and the response
// data from a small memory model.
module tb_mem_arbiter;
    import mem_arb_pkg::*;

    localparam int N = 2;

    logic              clk;
    logic              rst_n;
    logic [N-1:0]      m_addr_valid;
    logic [32*N-1:0]   m_addr;
    logic [N-1:0]      m_data_valid;
    logic [32*N-1:0]   m_data;
    logic [N-1:0]      m_ready;
    logic [N-1:0]      m_resp_valid;
    logic [31:0]       m_resp_data;
    logic [N-1:0]      m_resp_ready;
    logic              c_addr_valid;
    logic [31:0]       c_addr;
    logic              c_data_valid;
    logic [31:0]       c_data;
    logic              c_ready;
    logic              c_send_valid;
    logic [31:0]       c_send_data;
    logic              c_send_ready;
    logic [N-1:0]      grant;
    logic              busy;
    state_t            state_dbg;

    mem_arbiter #(.NUM_PORTS(N)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .m_addr_valid (m_addr_valid),
        .m_addr       (m_addr),
        .m_data_valid (m_data_valid),
        .m_data       (m_data),
        .m_ready      (m_ready),
        .m_resp_valid (m_resp_valid),
        .m_resp_data  (m_resp_data),
        .m_resp_ready (m_resp_ready),
        .c_addr_valid (c_addr_valid),
        .c_addr       (c_addr),
        .c_data_valid (c_data_valid),
        .c_data       (c_data),
        .c_ready      (c_ready),
        .c_send_valid (c_send_valid),
        .c_send_data  (c_send_data),
        .c_send_ready (c_send_ready),
        .grant        (grant),
        .busy         (busy),
        .state_dbg    (state_dbg)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    // ---------------- bookkeeping ----------------
    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] exp_q[$];
    logic [31:0] cache_mem [logic [31:0]];

    logic [N-1:0] pend;
    logic [31:0]  req_addr [N];
    logic         req_wr   [N];
    logic [31:0]  req_data [N];
    int           model_last;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Arbitration rule, expressed on the set of pending ports.
    function automatic int model_pick(input logic [N-1:0] v);
`ifdef MEM_ARB_FIXED_PRIO_EN
        for (int i = 0; i < N; i++) if (v[i]) return i;
`else
        for (int k = 1; k <= N; k++) if (v[(model_last + k) % N]) return (model_last + k) % N;
`endif
        return -1;
    endfunction

    task automatic drive_reqs();
        for (int i = 0; i < N; i++) begin
            m_addr[i*32 +: 32] = req_addr[i];
            m_data[i*32 +: 32] = req_data[i];
            m_data_valid[i]    = req_wr[i];
        end
        m_addr_valid = pend;
    endtask

    task automatic set_req(input int p, input logic [31:0] a, input logic w, input logic [31:0] d);
        pend[p]     = 1'b1;
        req_addr[p] = a;
        req_wr[p]   = w;
        req_data[p] = d;
    endtask

    task automatic check_all_zero(input string pfx);
        check({pfx, "_m_ready"},      m_ready,      '0);
        check({pfx, "_m_resp_valid"}, m_resp_valid, '0);
        check({pfx, "_m_resp_data"},  m_resp_data,  '0);
        check({pfx, "_c_addr_valid"}, c_addr_valid, '0);
        check({pfx, "_c_addr"},       c_addr,       '0);
        check({pfx, "_c_data_valid"}, c_data_valid, '0);
        check({pfx, "_c_data"},       c_data,       '0);
        check({pfx, "_c_send_ready"}, c_send_ready, '0);
        check({pfx, "_grant"},        grant,        '0);
        check({pfx, "_busy"},         busy,         '0);
    endtask

    // One full transaction, starting with the arbiter idle and 'pend' set.
    task automatic run_txn(input int cache_lat, input int wait_lat, input int resp_lat, output int who);
        int           w;
        int           cnt;
        logic [N-1:0] oh;
        logic [31:0]  exp_a;
        logic [31:0]  exp_d;
        logic         exp_w;
        logic [31:0]  exp_wd;

        drive_reqs();
        w  = model_pick(pend);
        oh = '0;
        oh[w] = 1'b1;
        exp_a  = req_addr[w];
        exp_w  = req_wr[w];
        exp_wd = req_data[w];
        if (exp_w) begin
            cache_mem[exp_a] = exp_wd;
            exp_d = exp_wd;
        end else begin
            exp_d = cache_mem.exists(exp_a) ? cache_mem[exp_a] : ~exp_a;
        end
        exp_q.push_back(exp_d);

        cnt = 0;
        do begin
            tick();
            cnt++;
        end while (m_ready == '0 && cnt < 20);
        check("ready_latency", cnt, 1);
        check("m_ready", m_ready, oh);
        check("grant_accept", grant, oh);
        check("busy_accept", busy, 1'b1);

        tick();
        pend[w] = 1'b0;
        drive_reqs();
        check("issue_c_addr_valid", c_addr_valid, 1'b1);
        check("issue_c_addr", c_addr, exp_a);
        check("issue_c_data_valid", c_data_valid, exp_w);
        check("issue_c_data", c_data, exp_wd);
        check("issue_m_ready", m_ready, '0);

        repeat (cache_lat) begin
            tick();
            check("hold_c_addr_valid", c_addr_valid, 1'b1);
            check("hold_c_addr", c_addr, exp_a);
            check("hold_grant", grant, oh);
        end
        c_ready = 1'b1;
        tick();
        c_ready = 1'b0;
        check("wait_c_addr_valid", c_addr_valid, 1'b0);
        check("wait_c_send_ready", c_send_ready, 1'b1);

        repeat (wait_lat) begin
            tick();
            check("wait_hold_send_ready", c_send_ready, 1'b1);
            check("wait_no_resp", m_resp_valid, '0);
        end
        c_send_valid = 1'b1;
        c_send_data  = exp_d;
        tick();
        c_send_valid = 1'b0;
        c_send_data  = $urandom;
        check("resp_valid", m_resp_valid, oh);
        check("resp_data", m_resp_data, exp_q.pop_front());
        check("resp_send_ready", c_send_ready, 1'b0);
        check("resp_grant", grant, oh);

        m_resp_ready = N'($urandom) & ~oh;
        repeat (resp_lat) begin
            tick();
            check("resp_hold_valid", m_resp_valid, oh);
            check("resp_hold_data", m_resp_data, exp_d);
        end
        m_resp_ready = oh;
        tick();
        m_resp_ready = '0;
        check("done_resp_valid", m_resp_valid, '0);
        check("done_busy", busy, 1'b0);
        check("done_grant", grant, '0);
        model_last = w;
        who = w;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int who;
        int seq [4];
        int exp_seq [4];

        rst_n        = 1'b0;
        pend         = '0;
        m_addr_valid = '0;
        m_addr       = '0;
        m_data_valid = '0;
        m_data       = '0;
        m_resp_ready = '0;
        c_ready      = 1'b0;
        c_send_valid = 1'b0;
        c_send_data  = '0;
        model_last   = N - 1;
        for (int i = 0; i < N; i++) begin
            req_addr[i] = '0;
            req_wr[i]   = 1'b0;
            req_data[i] = '0;
        end

        tick();
        tick();
        check_all_zero("reset");
        check("reset_state", state_dbg, S_IDLE);
        rst_n = 1'b1;
        tick();
        check("idle_busy", busy, 1'b0);

        // Single read from port 0.
        cache_mem[32'h0000_0100] = 32'hDEAD_BEEF;
        set_req(0, 32'h0000_0100, 1'b0, 32'h0);
        run_txn(1, 1, 0, who);
        check("read_owner", who, 0);

        // Write from port 1 with cache and response back-pressure.
        set_req(1, 32'h0000_0200, 1'b1, 32'h1234_5678);
        run_txn(5, 0, 3, who);
        check("write_owner", who, 1);

        // Contention: both ports request continuously.
`ifdef MEM_ARB_FIXED_PRIO_EN
        exp_seq = '{0, 0, 0, 0};
`else
        exp_seq = '{0, 1, 0, 1};
`endif
        for (int t = 0; t < 4; t++) begin
            for (int p = 0; p < N; p++) begin
                if (!pend[p]) set_req(p, {26'($urandom_range(0, 15)), 6'h0}, 1'($urandom), $urandom);
            end
            run_txn(0, 0, 0, who);
            seq[t] = who;
        end
        pend = '0;
        drive_reqs();
        for (int t = 0; t < 4; t++) check("contention_order", seq[t], exp_seq[t]);

        // Withdrawal during accept.
        tick();
        set_req(0, 32'h0000_0300, 1'b0, 32'h0);
        drive_reqs();
        tick();
        check("wd_m_ready", m_ready, 2'b01);
        pend = '0;
        drive_reqs();
        tick();
        check("wd_busy", busy, 1'b0);
        check("wd_grant", grant, '0);
        check("wd_c_addr_valid", c_addr_valid, 1'b0);
        tick();
        check("wd_c_addr_valid_late", c_addr_valid, 1'b0);

        // Reset while waiting on the cache.
        set_req(1, 32'h0000_0400, 1'b0, 32'h0);
        drive_reqs();
        tick();
        check("rst_txn_m_ready", m_ready, 2'b10);
        tick();
        pend = '0;
        drive_reqs();
        c_ready = 1'b1;
        tick();
        c_ready = 1'b0;
        check("rst_txn_in_wait", c_send_ready, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("midrst");
        tick();
        tick();
        rst_n      = 1'b1;
        model_last = N - 1;
        set_req(0, 32'h0000_0500, 1'b0, 32'h0);
        set_req(1, 32'h0000_0600, 1'b0, 32'h0);
        run_txn(0, 0, 0, who);
        check("post_reset_owner", who, 0);
        pend = '0;
        drive_reqs();

        // Randomized traffic.
        for (int t = 0; t < 40; t++) begin
            if (pend == '0) begin
                repeat ($urandom_range(0, 2)) begin
                    tick();
                    check("rand_idle_busy", busy, 1'b0);
                end
            end
            for (int p = 0; p < N; p++) begin
                if (!pend[p] && $urandom_range(0, 1) == 1)
                    set_req(p, {26'($urandom_range(0, 15)), 6'h0}, 1'($urandom), $urandom);
            end
            if (pend == '0) set_req($urandom_range(0, N - 1), {26'($urandom_range(0, 15)), 6'h0}, 1'($urandom), $urandom);
            run_txn($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), who);
        end
        pend = '0;
        drive_reqs();
        tick();
        check("final_busy", busy, 1'b0);
        check("final_exp_q_empty", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
